fun: RTL and testbench

FUN -- requirements
Module: fun

---
 rtl/fun_if.sv | 27 ++
 rtl/fun.sv | 59 +++++
 tb/tb_fun.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fun_if.sv
// Dual-rail operand bundle and registered result/status of the fun block.
interface fun_if;
    logic       a;
    logic       not_a;
    logic       b;
    logic       not_b;
    logic       c;
    logic       not_c;
    logic       d;
    logic       not_d;
    logic       out;
    logic       err;
    logic       err_sticky;
    logic [7:0] err_cnt;

    // Stimulus side: drives the rails, observes the results.
    modport master (
        output a, not_a, b, not_b, c, not_c, d, not_d,
        input  out, err, err_sticky, err_cnt
    );

    // Block side: samples the rails, drives the results.
    modport slave (
        input  a, not_a, b, not_b, c, not_c, d, not_d,
        output out, err, err_sticky, err_cnt
    );
endinterface

// File: rtl/fun.sv
// Registered 4-input boolean function with dual-rail operand checking.
// F is evaluated from the true rails; complement rails only feed the
// rail-integrity check. A failing sample holds out and bumps the error
// status (saturating counter, sticky flag).
module fun (
    input  logic clk,
    input  logic rst_n,
    fun_if.slave bus
);

    // Bit i is F(idx = i); ones at 0,2,5,7,8,10,13,14,15.
    localparam logic [15:0] F_TABLE = 16'hE5A5;

    logic [3:0] w_idx;
    logic       w_f;
    logic [3:0] w_pair_ok;
    logic       w_rail_ok;

    logic       r_out;
    logic       r_err;
    logic       r_err_sticky;
    logic [7:0] r_err_cnt;

    assign w_idx = {bus.a, bus.b, bus.c, bus.d};
    assign w_f   = F_TABLE[w_idx];

    // An X/Z rail makes the XOR unknown; the `if` below then takes the
    // error branch, so undriven rails count as invalid in simulation.
    assign w_pair_ok = {bus.a ^ bus.not_a,
                        bus.b ^ bus.not_b,
                        bus.c ^ bus.not_c,
                        bus.d ^ bus.not_d};
    assign w_rail_ok = &w_pair_ok;

    // Sample on every edge: valid rails load F, invalid rails hold out and log the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_rail_ok) begin
            r_out <= w_f;
            r_err <= 1'b0;
        end else begin
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.out        = r_out;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_fun.sv
// Directed self-checking bench for fun.
module tb_fun;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fun_if bus ();

    fun u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-listed minterms of F.
    int ones [9] = '{0, 2, 5, 7, 8, 10, 13, 14, 15};

    function automatic logic exp_f(input int idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (ones[k] == idx) r = 1'b1;
        end
        return r;
    endfunction

    task automatic drive_idx(input int idx);
        logic [3:0] v;
        v = idx[3:0];
        bus.a = v[3]; bus.not_a = ~v[3];
        bus.b = v[2]; bus.not_b = ~v[2];
        bus.c = v[1]; bus.not_c = ~v[1];
        bus.d = v[0]; bus.not_d = ~v[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idx(0);               // F=1, must not reach out while in reset
        step();
        step();
        total++;
        if (bus.out !== 1'b0 || bus.err !== 1'b0 || bus.err_sticky !== 1'b0 || bus.err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: out=%b err=%b sticky=%b cnt=%0d required 0 0 0 0",
                     bus.out, bus.err, bus.err_sticky, bus.err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            drive_idx(i);
            step();
            total++;
            if (bus.out !== exp_f(i) || bus.err !== 1'b0) begin
                bad++;
                $display("FAIL sweep idx=%0d: out=%b err=%b required out=%b err=0",
                         i, bus.out, bus.err, exp_f(i));
            end
        end
    endtask

    task automatic test_rail_error();
        drive_idx(5);
        step();
        total++;
        if (bus.out !== 1'b1) begin
            bad++;
            $display("FAIL rail_pre: out=%b required 1", bus.out);
        end
        bus.a = 1'b1; bus.not_a = 1'b1;
        step();
        total++;
        if (bus.out !== 1'b1 || bus.err !== 1'b1 || bus.err_sticky !== 1'b1 || bus.err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL rail_err: out=%b err=%b sticky=%b cnt=%0d required 1 1 1 1",
                     bus.out, bus.err, bus.err_sticky, bus.err_cnt);
        end
        drive_idx(6);
        step();
        total++;
        if (bus.out !== 1'b0 || bus.err !== 1'b0 || bus.err_sticky !== 1'b1 || bus.err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL rail_recover: out=%b err=%b sticky=%b cnt=%0d required 0 0 1 1",
                     bus.out, bus.err, bus.err_sticky, bus.err_cnt);
        end
    endtask

    task automatic test_saturate();
        // err_cnt starts at 1 from the previous test.
        drive_idx(2);
        bus.c = 1'b0; bus.not_c = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (n == 1 || n == 253 || n == 254 || n == 255 || n == 300) begin
                int exp_cnt;
                exp_cnt = (n + 1 > 255) ? 255 : n + 1;
                total++;
                if (bus.err_cnt !== exp_cnt[7:0] || bus.err !== 1'b1 || bus.out !== 1'b0) begin
                    bad++;
                    $display("FAIL saturate n=%0d: cnt=%0d err=%b out=%b required cnt=%0d err=1 out=0",
                             n, bus.err_cnt, bus.err, bus.out, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive_idx(5);
        step();
        bus.b = 1'b0; bus.not_b = 1'b0;
        step(); step(); step();
        total++;
        if (bus.out !== 1'b1 || bus.err_cnt !== 8'd3 || bus.err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL async_pre: out=%b cnt=%0d sticky=%b required 1 3 1",
                     bus.out, bus.err_cnt, bus.err_sticky);
        end
        #2;                         // mid-cycle, well away from any edge
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out !== 1'b0 || bus.err !== 1'b0 || bus.err_sticky !== 1'b0 || bus.err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: out=%b err=%b sticky=%b cnt=%0d required 0 0 0 0",
                     bus.out, bus.err, bus.err_sticky, bus.err_cnt);
        end
    endtask

    task automatic test_after_reset();
        drive_idx(15);
        step();
        total++;
        if (bus.out !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: out=%b required 0", bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (bus.out !== 1'b1 || bus.err !== 1'b0 || bus.err_cnt !== 8'd0 || bus.err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: out=%b err=%b sticky=%b cnt=%0d required 1 0 0 0",
                     bus.out, bus.err, bus.err_sticky, bus.err_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive_idx(0);
        test_reset();
        test_sweep();
        test_rail_error();
        test_saturate();
        test_async_reset();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
